// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : core request/ack bundle and RAM port for mem_arbiter
// Rev 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int NCORE = 4
);
    logic [NCORE-1:0]    core_read;
    logic [NCORE-1:0]    core_write;
    logic [16*NCORE-1:0] core_read_adr;
    logic [16*NCORE-1:0] core_write_adr;
    logic [16*NCORE-1:0] core_write_dat;
    logic [NCORE-1:0]    core_ac;
    logic [15:0]         core_rdat;
    logic [10*NCORE-1:0] core_lock_adr;
    logic [NCORE-1:0]    core_lock_en;
    logic [NCORE-1:0]    core_unlock_en;
    logic [NCORE-1:0]    core_lock_ac;
    logic [15:0]         ram_radr;
    logic [15:0]         ram_wadr;
    logic [15:0]         ram_wdat;
    logic                ram_we;
    logic [15:0]         ram_rdat;

    // Environment side: cores issue requests, the RAM returns read data.
    modport master (
        output core_read, core_write, core_read_adr, core_write_adr, core_write_dat,
        output core_lock_adr, core_lock_en, core_unlock_en, ram_rdat,
        input  core_ac, core_rdat, core_lock_ac, ram_radr, ram_wadr, ram_wdat, ram_we
    );

    modport slave (
        input  core_read, core_write, core_read_adr, core_write_adr, core_write_dat,
        input  core_lock_adr, core_lock_en, core_unlock_en, ram_rdat,
        output core_ac, core_rdat, core_lock_ac, ram_radr, ram_wadr, ram_wdat, ram_we
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin RAM arbiter; lock table enabled by MEM_ARBITER_LOCK_EN
// Rev 1.0
// ============================================================================
module mem_arbiter #(
    parameter int NCORE = 4,
    parameter int NLOCK = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int OW = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam logic [OW-1:0] c_last = OW'(NCORE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    function automatic logic [OW-1:0] f_next(input logic [OW-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [OW:0] f_rr_pick(input logic [NCORE-1:0] req,
                                              input logic [OW-1:0]    ptr);
        logic          found;
        logic [OW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCORE; k++) begin
            int j;
            j = (int'(ptr) + k) % NCORE;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = OW'(j);
            end
        end
        return {found, idx};
    endfunction

    // ------------------------------------------------------------------------
    // Memory transaction FSM
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [OW-1:0]    r_ptr;
    logic [OW-1:0]    r_gnt;
    logic             r_rd;
    logic             r_wr;
    logic [15:0]      r_radr;
    logic [15:0]      r_wadr;
    logic [15:0]      r_wdat;
    logic [NCORE-1:0] w_req;
    logic             w_mpick_ok;
    logic [OW-1:0]    w_mpick_g;
    logic [NCORE-1:0] w_core_ac;
    logic [15:0]      w_core_rdat;
    logic             w_ram_we;

    assign w_req = bus.core_read | bus.core_write;
    assign {w_mpick_ok, w_mpick_g} = f_rr_pick(w_req, r_ptr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_radr  <= '0;
            r_wadr  <= '0;
            r_wdat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_mpick_ok) begin
                r_gnt  <= w_mpick_g;
                r_rd   <= bus.core_read[w_mpick_g];
                r_wr   <= bus.core_write[w_mpick_g];
                r_radr <= bus.core_read_adr[16*w_mpick_g +: 16];
                r_wadr <= bus.core_write_adr[16*w_mpick_g +: 16];
                r_wdat <= bus.core_write_dat[16*w_mpick_g +: 16];
            end
            if (r_state == S_ACK) begin
                r_ptr <= f_next(r_gnt);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_core_ac   = '0;
        w_core_rdat = '0;
        w_ram_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mpick_ok) begin
                    w_state_nxt = S_MEM;
                end
            end
            S_MEM: begin
                // RAM samples the write here, so it commits on the MEM->ACK edge.
                w_ram_we    = r_wr;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_core_ac[r_gnt] = 1'b1;
                if (r_rd) begin
                    w_core_rdat = bus.ram_rdat;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.core_ac   = w_core_ac;
    assign bus.core_rdat = w_core_rdat;
    assign bus.ram_radr  = r_radr;
    assign bus.ram_wadr  = r_wadr;
    assign bus.ram_wdat  = r_wdat;
    assign bus.ram_we    = w_ram_we;

    // ------------------------------------------------------------------------
    // Lock unit: one lock/unlock operation per cycle, round-robin
    // ------------------------------------------------------------------------
    logic [NCORE-1:0] r_lock_ac;
    logic [OW-1:0]    r_lptr;
    logic [NCORE-1:0] w_lreq;
    logic             w_lpick_ok;
    logic [OW-1:0]    w_lpick_g;
    logic             w_lock_ok;

    // A core whose ack is visible this cycle has not yet dropped its request.
    assign w_lreq = (bus.core_lock_en | bus.core_unlock_en) & ~r_lock_ac;
    assign {w_lpick_ok, w_lpick_g} = f_rr_pick(w_lreq, r_lptr);
    assign bus.core_lock_ac = r_lock_ac;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lock_ac <= '0;
            r_lptr    <= '0;
        end else begin
            r_lock_ac <= '0;
            if (w_lock_ok) begin
                r_lock_ac[w_lpick_g] <= 1'b1;
            end
            // Advance even on a refused lock so a stalled core cannot starve the rest.
            if (w_lpick_ok) begin
                r_lptr <= f_next(w_lpick_g);
            end
        end
    end

`ifdef MEM_ARBITER_LOCK_EN
    localparam int LW = (NLOCK > 1) ? $clog2(NLOCK) : 1;

    logic [NLOCK-1:0]    r_lk_valid;
    logic [10*NLOCK-1:0] r_lk_adr;
    logic [OW*NLOCK-1:0] r_lk_own;
    logic [9:0]          w_lk_adr;
    logic                w_unlock;
    logic                w_hit;
    logic                w_hit_mine;
    logic [LW-1:0]       w_hit_idx;
    logic                w_free;
    logic [LW-1:0]       w_free_idx;

    always_comb begin
        w_lk_adr   = bus.core_lock_adr[10*w_lpick_g +: 10];
        w_unlock   = bus.core_unlock_en[w_lpick_g];
        w_hit      = 1'b0;
        w_hit_mine = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int e = 0; e < NLOCK; e++) begin
            if (!w_hit && r_lk_valid[e] && r_lk_adr[10*e +: 10] == w_lk_adr) begin
                w_hit      = 1'b1;
                w_hit_idx  = LW'(e);
                w_hit_mine = (r_lk_own[OW*e +: OW] == w_lpick_g);
            end
            if (!w_free && !r_lk_valid[e]) begin
                w_free     = 1'b1;
                w_free_idx = LW'(e);
            end
        end
        w_lock_ok = w_lpick_ok && (w_unlock || (w_hit ? w_hit_mine : w_free));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lk_valid <= '0;
            r_lk_adr   <= '0;
            r_lk_own   <= '0;
        end else if (w_lpick_ok) begin
            if (w_unlock) begin
                if (w_hit && w_hit_mine) begin
                    r_lk_valid[w_hit_idx] <= 1'b0;
                end
            end else if (!w_hit && w_free) begin
                r_lk_valid[w_free_idx]           <= 1'b1;
                r_lk_adr[10*w_free_idx +: 10]    <= w_lk_adr;
                r_lk_own[OW*w_free_idx +: OW]    <= w_lpick_g;
            end
        end
    end
`else
    localparam int c_unused_nlock = NLOCK;
    logic w_unused_lock;

    // Without a table every lock or unlock is granted as soon as it is picked.
    assign w_lock_ok     = w_lpick_ok;
    assign w_unused_lock = ^bus.core_lock_adr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;
    localparam int NCORE = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] mem [0:65535];

    mem_arbiter_if #(.NCORE(NCORE)) bus ();

    mem_arbiter #(.NCORE(NCORE), .NLOCK(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        bus.ram_rdat <= mem[bus.ram_radr];
        if (bus.ram_we) mem[bus.ram_wadr] <= bus.ram_wdat;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.core_read      = '0;
        bus.core_write     = '0;
        bus.core_read_adr  = '0;
        bus.core_write_adr = '0;
        bus.core_write_dat = '0;
        bus.core_lock_adr  = '0;
        bus.core_lock_en   = '0;
        bus.core_unlock_en = '0;
    endtask

    task automatic set_rd(input int c, input logic [15:0] a);
        bus.core_read_adr[16*c +: 16] = a;
        bus.core_read[c] = 1'b1;
    endtask

    task automatic set_wr(input int c, input logic [15:0] a, input logic [15:0] d);
        bus.core_write_adr[16*c +: 16] = a;
        bus.core_write_dat[16*c +: 16] = d;
        bus.core_write[c] = 1'b1;
    endtask

    task automatic set_ladr(input int c, input logic [9:0] a);
        bus.core_lock_adr[10*c +: 10] = a;
    endtask

    // n = cycles until core_ac[c], or -1 if the budget runs out.
    task automatic wait_mem_ack(input int c, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit && n < 0; k++) begin
            tick;
            if (bus.core_ac[c]) n = k;
        end
    endtask

    task automatic wait_lock_ack(input int c, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit && n < 0; k++) begin
            tick;
            if (bus.core_lock_ac[c]) n = k;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        clear_inputs;
        repeat (3) tick;
        total++;
        if ({bus.core_ac, bus.core_lock_ac, bus.core_rdat, bus.ram_we,
             bus.ram_radr, bus.ram_wadr, bus.ram_wdat} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ac=%b lock_ac=%b rdat=%h we=%b radr=%h wadr=%h wdat=%h, all required 0",
                     bus.core_ac, bus.core_lock_ac, bus.core_rdat, bus.ram_we,
                     bus.ram_radr, bus.ram_wadr, bus.ram_wdat);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_round_robin;
        int ack_core [4];
        int ack_cyc  [4];
        int nack = 0;
        int cyc  = 0;
        for (int c = 0; c < 4; c++) set_rd(c, 16'(16'h0100 + c));
        while (nack < 4 && cyc < 40) begin
            tick;
            cyc++;
            for (int c = 0; c < 4; c++) begin
                if (bus.core_ac[c]) begin
                    ack_core[nack] = c;
                    ack_cyc[nack]  = cyc;
                    nack++;
                    bus.core_read[c] = 1'b0;
                end
            end
        end
        total++;
        if (nack !== 4) begin
            bad++;
            $display("FAIL rr_ack_count: got %0d acks, required 4", nack);
        end
        for (int k = 0; k < nack; k++) begin
            total++;
            if (ack_core[k] !== k || ack_cyc[k] !== 2 + 3*k) begin
                bad++;
                $display("FAIL rr_order[%0d]: core %0d at cycle %0d, required core %0d at cycle %0d",
                         k, ack_core[k], ack_cyc[k], k, 2 + 3*k);
            end
        end
        tick;
        // Pointer wrapped past core3, so core0 wins over core1.
        set_rd(0, 16'h0000);
        set_rd(1, 16'h0001);
        tick;
        tick;
        total++;
        if (bus.core_ac !== 4'b0001) begin
            bad++;
            $display("FAIL rr_wrap: ac=%b required 0001", bus.core_ac);
        end
        bus.core_read = '0;
        tick;
    endtask

    task automatic test_write_read;
        int n;
        set_wr(0, 16'h0010, 16'h1234);
        wait_mem_ack(0, 10, n);
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL wr_latency: %0d cycles, required 2", n);
        end
        total++;
        if (bus.core_rdat !== 16'h0000) begin
            bad++;
            $display("FAIL wr_rdat_zero: rdat=%h required 0000", bus.core_rdat);
        end
        bus.core_write = '0;
        tick;
        set_rd(0, 16'h0010);
        wait_mem_ack(0, 10, n);
        total++;
        if (n !== 2 || bus.core_rdat !== 16'h1234) begin
            bad++;
            $display("FAIL rd_after_wr: latency %0d rdat=%h, required 2 and 1234", n, bus.core_rdat);
        end
        bus.core_read = '0;
        tick;
    endtask

    task automatic test_read_write_same;
        int   n;
        logic [NCORE-1:0] extra;
        set_wr(1, 16'h0020, 16'h0005);
        wait_mem_ack(1, 10, n);
        bus.core_write = '0;
        tick;
        set_wr(1, 16'h0020, 16'h0009);
        set_rd(1, 16'h0020);
        wait_mem_ack(1, 10, n);
        total++;
        if (n !== 2 || bus.core_rdat !== 16'h0005) begin
            bad++;
            $display("FAIL rw_old_data: latency %0d rdat=%h, required 2 and 0005", n, bus.core_rdat);
        end
        bus.core_read  = '0;
        bus.core_write = '0;
        extra = '0;
        repeat (3) begin
            tick;
            extra |= bus.core_ac;
        end
        total++;
        if (extra !== '0) begin
            bad++;
            $display("FAIL rw_single_ack: extra ack %b, required 0000", extra);
        end
        set_rd(1, 16'h0020);
        wait_mem_ack(1, 10, n);
        total++;
        if (n !== 2 || bus.core_rdat !== 16'h0009) begin
            bad++;
            $display("FAIL rw_new_data: latency %0d rdat=%h, required 2 and 0009", n, bus.core_rdat);
        end
        bus.core_read = '0;
        tick;
    endtask

    task automatic test_back_to_back;
        int n;
        logic [5:0] seen;
        logic [5:0] exp_seen;
        exp_seen = 6'b010101;
        set_ladr(1, 10'h055);
        bus.core_lock_en[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            seen[k] = bus.core_lock_ac[1];
        end
        bus.core_lock_en[1] = 1'b0;
        total++;
        if (seen !== exp_seen) begin
            bad++;
            $display("FAIL b2b_lock_ack: pattern %b, required %b", seen, exp_seen);
        end
        tick;
        bus.core_unlock_en[1] = 1'b1;
        wait_lock_ack(1, 6, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL b2b_unlock: %0d cycles, required 1", n);
        end
        bus.core_unlock_en[1] = 1'b0;
        tick;
    endtask

`ifdef MEM_ARBITER_LOCK_EN
    task automatic test_lock_contend;
        int n;
        logic [NCORE-1:0] stall;
        set_ladr(2, 10'h3A5);
        bus.core_lock_en[2] = 1'b1;
        wait_lock_ack(2, 6, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL lock_core2: %0d cycles, required 1", n);
        end
        bus.core_lock_en[2] = 1'b0;
        tick;
        set_ladr(0, 10'h3A5);
        bus.core_lock_en[0] = 1'b1;
        stall = '0;
        repeat (4) begin
            tick;
            stall |= bus.core_lock_ac;
        end
        total++;
        if (stall !== '0) begin
            bad++;
            $display("FAIL lock_held_stall: lock_ac seen %b, required 0000", stall);
        end
        bus.core_unlock_en[2] = 1'b1;
        tick;
        total++;
        if (bus.core_lock_ac !== 4'b0100) begin
            bad++;
            $display("FAIL unlock_core2: lock_ac=%b required 0100", bus.core_lock_ac);
        end
        bus.core_unlock_en[2] = 1'b0;
        tick;
        total++;
        if (bus.core_lock_ac !== 4'b0001) begin
            bad++;
            $display("FAIL lock_core0_after: lock_ac=%b required 0001", bus.core_lock_ac);
        end
        bus.core_lock_en[0] = 1'b0;
        tick;
        bus.core_lock_en[0] = 1'b1;
        wait_lock_ack(0, 6, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL lock_idempotent: %0d cycles, required 1", n);
        end
        bus.core_lock_en[0] = 1'b0;
        tick;
        // Unlock by a non-owner acks but must leave core0's entry in place.
        set_ladr(3, 10'h3A5);
        bus.core_unlock_en[3] = 1'b1;
        wait_lock_ack(3, 6, n);
        bus.core_unlock_en[3] = 1'b0;
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL unlock_not_owner: %0d cycles, required 1", n);
        end
        tick;
        bus.core_lock_en[2] = 1'b1;
        stall = '0;
        repeat (3) begin
            tick;
            stall |= bus.core_lock_ac;
        end
        bus.core_lock_en[2] = 1'b0;
        total++;
        if (stall !== '0) begin
            bad++;
            $display("FAIL entry_kept: lock_ac seen %b, required 0000", stall);
        end
        tick;
        bus.core_unlock_en[0] = 1'b1;
        wait_lock_ack(0, 6, n);
        bus.core_unlock_en[0] = 1'b0;
        tick;
    endtask

    task automatic test_table_full;
        int n;
        int nok = 0;
        logic [NCORE-1:0] stall;
        for (int k = 0; k < 8; k++) begin
            set_ladr(1, 10'(10'h100 + k));
            bus.core_lock_en[1] = 1'b1;
            wait_lock_ack(1, 6, n);
            if (n == 1) nok++;
            bus.core_lock_en[1] = 1'b0;
            tick;
        end
        total++;
        if (nok !== 8) begin
            bad++;
            $display("FAIL full_fill: %0d prompt acks, required 8", nok);
        end
        set_ladr(1, 10'h108);
        bus.core_lock_en[1] = 1'b1;
        stall = '0;
        repeat (5) begin
            tick;
            stall |= bus.core_lock_ac;
        end
        total++;
        if (stall !== '0) begin
            bad++;
            $display("FAIL full_stall: lock_ac seen %b, required 0000", stall);
        end
        bus.core_lock_en[1]   = 1'b0;
        set_ladr(1, 10'h100);
        bus.core_unlock_en[1] = 1'b1;
        wait_lock_ack(1, 6, n);
        bus.core_unlock_en[1] = 1'b0;
        tick;
        set_ladr(1, 10'h108);
        bus.core_lock_en[1] = 1'b1;
        wait_lock_ack(1, 6, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL full_ninth: %0d cycles, required 1", n);
        end
        bus.core_lock_en[1] = 1'b0;
        tick;
    endtask
`else
    task automatic test_lock_free;
        int n;
        set_ladr(2, 10'h3A5);
        bus.core_lock_en[2] = 1'b1;
        wait_lock_ack(2, 6, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL nolock_core2: %0d cycles, required 1", n);
        end
        bus.core_lock_en[2] = 1'b0;
        tick;
        set_ladr(0, 10'h3A5);
        bus.core_lock_en[0] = 1'b1;
        wait_lock_ack(0, 6, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL nolock_core0: %0d cycles, required 1", n);
        end
        bus.core_lock_en[0] = 1'b0;
        tick;
        // Two cores together: ack one per cycle in round-robin order (lptr=1 -> core2 first).
        bus.core_lock_en[0] = 1'b1;
        bus.core_lock_en[2] = 1'b1;
        tick;
        total++;
        if (bus.core_lock_ac !== 4'b0100) begin
            bad++;
            $display("FAIL nolock_rr_first: lock_ac=%b required 0100", bus.core_lock_ac);
        end
        bus.core_lock_en[2] = 1'b0;
        tick;
        total++;
        if (bus.core_lock_ac !== 4'b0001) begin
            bad++;
            $display("FAIL nolock_rr_second: lock_ac=%b required 0001", bus.core_lock_ac);
        end
        bus.core_lock_en[0] = 1'b0;
        tick;
    endtask
`endif

    task automatic test_reset_in_ack;
        int n;
        logic [NCORE-1:0] spurious;
        set_wr(3, 16'h0040, 16'hBEEF);
        wait_mem_ack(3, 10, n);
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL rst_pre_ack: %0d cycles, required 2", n);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({bus.core_ac, bus.core_lock_ac, bus.core_rdat, bus.ram_we, bus.ram_wadr, bus.ram_wdat} !== '0) begin
            bad++;
            $display("FAIL rst_in_ack: ac=%b lock_ac=%b rdat=%h we=%b wadr=%h wdat=%h, all required 0",
                     bus.core_ac, bus.core_lock_ac, bus.core_rdat, bus.ram_we, bus.ram_wadr, bus.ram_wdat);
        end
        total++;
        if (mem[16'h0040] !== 16'hBEEF) begin
            bad++;
            $display("FAIL rst_write_kept: ram[0040]=%h required beef", mem[16'h0040]);
        end
        clear_inputs;
        repeat (2) tick;
        reset = 1'b1;
        spurious = '0;
        repeat (5) begin
            tick;
            spurious |= bus.core_ac | bus.core_lock_ac;
        end
        total++;
        if (spurious !== '0) begin
            bad++;
            $display("FAIL rst_no_spurious: ack seen %b, required 0000", spurious);
        end
        // Core1 held 0x101 before reset; a cleared table lets core0 take it.
        set_ladr(0, 10'h101);
        bus.core_lock_en[0] = 1'b1;
        wait_lock_ack(0, 6, n);
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL rst_table_empty: %0d cycles, required 1", n);
        end
        bus.core_lock_en[0] = 1'b0;
        set_rd(1, 16'h0040);
        set_rd(3, 16'h0040);
        tick;
        tick;
        total++;
        if (bus.core_ac !== 4'b0010) begin
            bad++;
            $display("FAIL rst_ptr_zero: ac=%b required 0010", bus.core_ac);
        end
        clear_inputs;
        tick;
    endtask

    initial begin
        clear_inputs;
        test_reset;
        test_round_robin;
        test_write_read;
        test_read_write_same;
        test_back_to_back;
`ifdef MEM_ARBITER_LOCK_EN
        test_lock_contend;
        test_table_full;
`else
        test_lock_free;
`endif
        test_reset_in_ack;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
